// File: rtl/fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default sizes and Gray/binary conversion.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;

    // Pointers of any width up to 32 bits fit. The caller zero-extends the
    // input and truncates the result back to its own pointer width.
    localparam int FIFO_PTR_MAX = 32;

    function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] g);
        logic [FIFO_PTR_MAX-1:0] b;
        b = g;
        for (int i = 1; i < FIFO_PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side FIFO bus. The producer and synchronizer side use the master
// modport and the pointer/flag controller uses the slave modport.
// Handshake: a write is taken on a wclk edge where winc=1 and wfull=0. When
// winc=1 and wfull=1 the write is dropped and recorded in woverflow. winc
// needs no hold or acknowledge beyond that single edge.
interface wptr_full_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  wfull;
    logic                  walmost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  woverflow;

    modport master (
        output winc, wq2_rptr,
        input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr,
        output waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag controller for the asynchronous FIFO.
// It counts accepted writes and publishes a Gray write pointer. It derives
// full, almost-full, fill level and a sticky overflow flag by comparing
// against the read pointer that has already been synchronized into wclk.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = 12
) (
    input logic        wclk,
    input logic        wrst_n,
    wptr_full_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          accept;
    logic          full_next;

    // Next-pointer arithmetic plus full and level compares for this cycle.
    always_comb begin
        accept     = bus.winc && !bus.wfull;
        wbinnext   = wbin + PW'(accept);
        wgraynext  = PW'(bin2gray(FIFO_PTR_MAX'(wbinnext)));
        rbin       = PW'(gray2bin(FIFO_PTR_MAX'(bus.wq2_rptr)));
        level_next = wbinnext - rbin;
        // The FIFO is full when the pointers match in the address bits but
        // differ in the wrap bit. In Gray code that means the top two bits
        // are inverted and the rest are equal.
        full_next  = (wgraynext == {~bus.wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                                    bus.wq2_rptr[ADDR_WIDTH-2:0]});
    end

    // The memory writes the slot addressed before the increment.
    assign bus.waddr = wbin[ADDR_WIDTH-1:0];

    // Register the pointers and flags. Synchronous reset clears everything.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin             <= '0;
            bus.wptr         <= '0;
            bus.wfull        <= 1'b0;
            bus.walmost_full <= 1'b0;
            bus.wlevel       <= '0;
            bus.woverflow    <= 1'b0;
        end else begin
            wbin             <= wbinnext;
            bus.wptr         <= wgraynext;
            bus.wfull        <= full_next;
            bus.walmost_full <= (level_next >= AFULL_LVL);
            bus.wlevel       <= level_next;
            bus.woverflow    <= bus.woverflow | (bus.winc && bus.wfull);
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full. The reference model tracks total write
// and read counts as plain integers and derives occupancy and flags from them.
module tb_wptr_full;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 2 * DEPTH;
    localparam int ATH   = 12;

    logic wclk;
    logic wrst_n;

    wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(ATH)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    // Clock generation.
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;

    // Model state: total accepted writes, reads visible to the write side,
    // the full flag as last registered, and the sticky overflow flag.
    int m_wr   = 0;
    int m_rd   = 0;
    bit m_full = 0;
    bit m_ovf  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_gray(input int count);
        int b;
        b = count % PMOD;
        return 32'(b ^ (b >> 1));
    endfunction

    // Compare every output against the model.
    task automatic check_all();
        int lvl;
        lvl = m_wr - m_rd;
        check("wptr",         32'(bus.wptr),         to_gray(m_wr));
        check("waddr",        32'(bus.waddr),        32'(m_wr % DEPTH));
        check("wlevel",       32'(bus.wlevel),       32'(lvl));
        check("wfull",        32'(bus.wfull),        32'(lvl == DEPTH));
        check("walmost_full", 32'(bus.walmost_full), 32'(lvl >= ATH));
        check("woverflow",    32'(bus.woverflow),    32'(m_ovf));
    endtask

    // One clock: apply inputs, step the model across the edge, then check.
    // rd_new is the total read count that the synchronized pointer shows.
    task automatic cycle(input logic inc, input int rd_new, input logic rst_n);
        bus.winc     = inc;
        bus.wq2_rptr = AW'(0) + (AW+1)'(to_gray(rd_new));
        wrst_n       = rst_n;
        @(posedge wclk);
        #1;
        if (!rst_n) begin
            m_wr   = 0;
            m_rd   = 0;
            m_full = 0;
            m_ovf  = 0;
        end else begin
            if (inc && m_full) m_ovf = 1;
            if (inc && !m_full) m_wr++;
            m_rd   = rd_new;
            m_full = ((m_wr - m_rd) == DEPTH);
        end
        check_all();
    endtask

    logic [AW:0] prev_ptr;
    int          rd_step;
    int          start_wr;

    initial begin
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;
        wrst_n       = 1'b0;

        // Reset held for 3 edges with winc high.
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0);
        check("reset_wptr", 32'(bus.wptr), 32'd0);

        // First writes: Gray sequence 00001, 00011, 00010.
        cycle(1'b1, 0, 1'b1);
        check("first_g1", 32'(bus.wptr), 32'b00001);
        cycle(1'b1, 0, 1'b1);
        check("first_g2", 32'(bus.wptr), 32'b00011);
        cycle(1'b1, 0, 1'b1);
        check("first_g3", 32'(bus.wptr), 32'b00010);
        check("first_addr", 32'(bus.waddr), 32'd3);

        // Fill to 16 entries.
        for (int i = 3; i < DEPTH; i++) begin
            cycle(1'b1, 0, 1'b1);
            if (i + 1 == ATH) check("afull_at_12", 32'(bus.walmost_full), 32'd1);
        end
        check("fill_full", 32'(bus.wfull), 32'd1);
        check("fill_wptr", 32'(bus.wptr), 32'b11000);
        check("fill_level", 32'(bus.wlevel), 32'd16);

        // A 17th request is dropped and latches overflow.
        cycle(1'b1, 0, 1'b1);
        check("ovf_wptr", 32'(bus.wptr), 32'b11000);
        check("ovf_set", 32'(bus.woverflow), 32'd1);

        // Drain one entry, then refill.
        cycle(1'b0, 1, 1'b1);
        check("drain_full", 32'(bus.wfull), 32'd0);
        check("drain_level", 32'(bus.wlevel), 32'd15);
        cycle(1'b1, 1, 1'b1);
        check("refill_full", 32'(bus.wfull), 32'd1);
        check("ovf_sticky", 32'(bus.woverflow), 32'd1);

        // Wrap: start from reset and keep the reader 4 entries behind.
        cycle(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            prev_ptr = bus.wptr;
            cycle(1'b1, m_wr + 1 - 4, 1'b1);
            check("wrap_onebit", 32'($countones(prev_ptr ^ bus.wptr)), 32'd1);
            check("wrap_level", 32'(bus.wlevel), 32'd4);
        end
        check("wrap_passed", 32'(m_wr > PMOD), 32'd1);

        // Randomized writes and reads; reads never pass accepted writes.
        for (int i = 0; i < 400; i++) begin
            rd_step = $urandom_range(0, 3);
            if (rd_step > m_wr - m_rd) rd_step = m_wr - m_rd;
            if ($urandom_range(0, 3) == 0) rd_step = 0;
            cycle(1'($urandom_range(0, 99) < 65), m_rd + rd_step, 1'b1);
        end

        // Mid-operation reset at level 10.
        cycle(1'b0, 0, 1'b0);
        start_wr = 0;
        while (m_wr - m_rd < 10 && start_wr < 50) begin
            cycle(1'b1, m_rd, 1'b1);
            start_wr++;
        end
        check("mid_level10", 32'(bus.wlevel), 32'd10);
        cycle(1'b1, 0, 1'b0);
        check("mid_rst_wptr", 32'(bus.wptr), 32'd0);
        check("mid_rst_addr", 32'(bus.waddr), 32'd0);
        cycle(1'b1, 0, 1'b1);
        check("mid_first_wptr", 32'(bus.wptr), 32'b00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO, running entirely in the write clock domain. It counts accepted writes, drives the write address and write enable gating into the dual-port FIFO memory, and publishes a Gray-coded write pointer for synchronization into the read domain. It compares against the read pointer already synchronized into the write domain to produce `wfull`, an almost-full flag, a fill level, and a sticky overflow flag.

## Interface
- `ADDR_WIDTH`, 4, memory address width; FIFO depth is 2^ADDR_WIDTH.
- `AFULL_THRESH`, 12, fill level at or above which `walmost_full` asserts. Legal range is 1..2^ADDR_WIDTH.
- `wclk`  in  1  write clock; the only clock in this block.
- `wrst_n`  in  1  reset; synchronous, active-low.
- `winc`  in  1  write request for the current cycle. It is also routed directly to the memory `wclken`.
- `wq2_rptr`  in  ADDR_WIDTH+1  Gray-coded read pointer, already two-flop synchronized into `wclk`.
- `waddr`  out  ADDR_WIDTH  memory write address; the low bits of the binary write pointer.
- `wptr`  out  ADDR_WIDTH+1  registered Gray-coded write pointer, sent to the read-domain synchronizer.
- `wfull`  out  1  FIFO full. It goes to the memory `wfull` port and to the producer.
- `walmost_full`  out  1  level ≥ `AFULL_THRESH`.
- `wlevel`  out  ADDR_WIDTH+1  entries held, from the write side's view (0..2^ADDR_WIDTH).
- `woverflow`  out  1  sticky: a write was attempted while full.

## Operation
- **Internal state:** binary pointer `wbin`, ADDR_WIDTH+1 bits.
- **Accepted write:** a write is accepted when `winc && !wfull`.
  - `wbinnext = wbin + accepted`, using modulo 2^(ADDR_WIDTH+1) wrap.
  - `wgraynext = wbinnext ^ (wbinnext >> 1)`.
- **Registered on every `wclk` edge with `wrst_n=1`:**
  - `wbin <= wbinnext`
  - `wptr <= wgraynext`
- **Address output:** `waddr = wbin[ADDR_WIDTH-1:0]`. This is combinational from the register, so the memory writes the slot addressed before the increment.
- **Full:** `wfull <= (wgraynext == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]})`.
- **Level:**
  - `rbin = gray2bin(wq2_rptr)`.
  - `wlevel <= wbinnext - rbin`, computed modulo 2^(ADDR_WIDTH+1).
  - The level never exceeds 2^ADDR_WIDTH.
- **Almost full:** `walmost_full <= (wbinnext - rbin) >= AFULL_THRESH`.
- **Overflow:** `woverflow <= woverflow | (winc && wfull)`. It is cleared only by reset.
- **Rejected write while full:** pointers hold and the memory is not written, because the memory also gates on `wfull`.
- **Conservative flags:** full, almost-full and level are pessimistic. Reads become visible only after `wq2_rptr` advances, which is at least 2 `wclk` after the read. The block never reports less occupancy than actual.
- **Reset:** when `wrst_n=0` at a `wclk` edge, all outputs and `wbin` become 0, and `winc` is ignored that cycle.
  - Values after reset: `waddr=0`, `wptr=0`, `wfull=0`, `walmost_full=0`, `wlevel=0`, `woverflow=0`.
  - Reset mid-operation discards all pointer state. The read domain must be reset in the same window; this block does not coordinate that.

## Timing
- **Write to full:** `wfull` asserts on the same edge that accepts the write filling the last slot. A write in the next cycle is already blocked, so there is zero-cycle flag latency.
- **Full release:** `wfull` deasserts on the first edge after `wq2_rptr` shows a read. There is no deassertion latency beyond the external synchronizer.
- **Simultaneous write and read:** a write accepted in the same cycle that `wq2_rptr` advances leaves `wlevel` unchanged.
- **Pointer stepping:** `wptr` changes by exactly one Gray bit per accepted write, including across the 2^(ADDR_WIDTH+1) wrap back to 0.
- **Almost-full and level:** `walmost_full` and `wlevel` update on the same edge as `wptr`.

## Structure
- **Shared package `fifo_pkg`:**
  - functions `bin2gray` and `gray2bin`, parameterized by width or written generically with a loop;
  - default constants for `ADDR_WIDTH` (4) and `DATA_WIDTH` (8).
- **Sub-modules:** none. This is a flat module. The external `sync_r2w` synchronizer that produces `wq2_rptr` is a separate neighbouring block and is not instantiated here.

## Test plan
All scenarios use the default parameters (ADDR_WIDTH=4, AFULL_THRESH=12).
- **Reset:** hold `wrst_n=0` for 3 edges with `winc=1` → all outputs 0 and `waddr=0`.
- **First writes:** 3 writes with `wq2_rptr=0` → `wptr` steps through 00001, 00011, 00010; `waddr`=3 and `wlevel`=3 after the third.
- **Fill:** 16 writes with `wq2_rptr=0` →
  - `walmost_full`=1 from the 12th edge;
  - `wfull`=1 on the 16th edge, with `wptr`=11000 and `wlevel`=16;
  - a 17th `winc` leaves `wptr` unchanged and sets `woverflow`=1 permanently.
- **Drain:** from full, set `wq2_rptr`=00001 (one read) → `wfull`=0 next edge, `wlevel`=15; then one write → `wfull`=1 again.
- **Wrap:** stream 40 writes while `wq2_rptr` tracks the read side 4 entries behind →
  - `wptr` wraps past 10000 (binary 31→0) with single-bit Gray changes;
  - `wlevel` stays at 4;
  - `wfull` never asserts.
- **Mid-operation reset:** at level 10, assert `wrst_n=0` for 1 edge → everything returns to 0; the next write produces `waddr=0` and `wptr=00001`.
